// File: rtl/dsc_slice_depacketizer_if.sv
// Byte-stream interface for the DSC slice depacketizer: compressed bytes in, chunk-marked bytes out.
// master drives the input stream and accepts the output stream; slave is the depacketizer side.
interface dsc_slice_depacketizer_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_soc;
   logic       out_eoc;
   logic       out_eos;
   logic [7:0] out_csum;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_soc, out_eoc, out_eos, out_csum
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_soc, out_eoc, out_eos, out_csum
   );
endinterface

// File: rtl/dsc_slice_depacketizer.sv
// DSC decoder input stage: splits one slice of compressed bytes into per-line chunks with soc/eoc/eos marks.
// Optional per-chunk XOR checksum on out_csum when DSC_CHUNK_CSUM_EN is defined.
module dsc_slice_depacketizer #(
   parameter int unsigned WIDTH_W = 16,
   parameter int unsigned BPP_W   = 10,
   parameter int unsigned CHUNK_W = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH_W-1:0] cfg_slice_width,
   input  logic [WIDTH_W-1:0] cfg_slice_height,
   input  logic [BPP_W-1:0]   cfg_bpp,
   output logic               busy,
   output logic               done,
   output logic               err,
   dsc_slice_depacketizer_if.slave bus
);

   localparam int unsigned SUM_W = WIDTH_W + BPP_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_STREAM, S_DONE} state_t;

   state_t             state;
   logic [WIDTH_W-1:0] width_q;
   logic [WIDTH_W-1:0] height_q;
   logic [BPP_W-1:0]   bpp_q;
   logic [CHUNK_W-1:0] chunk_q;
   logic [CHUNK_W-1:0] byte_cnt;
   logic [WIDTH_W-1:0] line_cnt;
   logic               eos_taken;
   logic               out_valid_q;
   logic [7:0]         data_q;
   logic               soc_q;
   logic               eoc_q;
   logic               eos_q;

   logic [SUM_W-1:0]   rounded_c;
   logic [CHUNK_W-1:0] chunk_c;
   logic               in_ready_c;
   logic               in_fire_c;
   logic               out_fire_c;
   logic               soc_c;
   logic               eoc_c;
   logic               eos_c;

   // Full-width product so the round-up to whole bytes never loses upper bits.
   assign rounded_c  = SUM_W'(width_q) * SUM_W'(bpp_q) + SUM_W'(127);
   assign chunk_c    = CHUNK_W'(rounded_c >> 7);

   assign in_ready_c = (state == S_STREAM) && !eos_taken && (!out_valid_q || bus.out_ready);
   assign in_fire_c  = bus.in_valid && in_ready_c;
   assign out_fire_c = out_valid_q && bus.out_ready;

   assign soc_c = (byte_cnt == '0);
   assign eoc_c = (byte_cnt == chunk_q - CHUNK_W'(1));
   assign eos_c = eoc_c && (line_cnt == height_q - WIDTH_W'(1));

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_soc   = soc_q;
   assign bus.out_eoc   = eoc_q;
   assign bus.out_eos   = eos_q;

   // Slice sequencing FSM with the single output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         width_q     <= '0;
         height_q    <= '0;
         bpp_q       <= '0;
         chunk_q     <= '0;
         byte_cnt    <= '0;
         line_cnt    <= '0;
         eos_taken   <= 1'b0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         soc_q       <= 1'b0;
         eoc_q       <= 1'b0;
         eos_q       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  width_q   <= cfg_slice_width;
                  height_q  <= cfg_slice_height;
                  bpp_q     <= cfg_bpp;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  byte_cnt  <= '0;
                  line_cnt  <= '0;
                  eos_taken <= 1'b0;
                  state     <= S_CALC;
               end
            end
            S_CALC: begin
               chunk_q <= chunk_c;
               if (chunk_c == '0 || height_q == '0) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (out_fire_c) out_valid_q <= 1'b0;
               if (in_fire_c) begin
                  out_valid_q <= 1'b1;
                  data_q      <= bus.in_data;
                  soc_q       <= soc_c;
                  eoc_q       <= eoc_c;
                  eos_q       <= eos_c;
                  byte_cnt    <= eoc_c ? '0 : byte_cnt + CHUNK_W'(1);
                  if (eoc_c) line_cnt <= line_cnt + WIDTH_W'(1);
                  if (eos_c) eos_taken <= 1'b1;
               end
               // Slice completes only once the eos byte leaves the output register.
               if (out_fire_c && eos_q) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DSC_CHUNK_CSUM_EN
   logic [7:0] csum_acc;
   logic [7:0] csum_q;
   logic [7:0] csum_nxt_c;

   assign csum_nxt_c   = soc_c ? bus.in_data : (csum_acc ^ bus.in_data);
   assign bus.out_csum = csum_q;

   // Running XOR per chunk; published alongside the eoc byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_acc <= '0;
         csum_q   <= '0;
      end else if (in_fire_c) begin
         csum_acc <= csum_nxt_c;
         if (eoc_c) csum_q <= csum_nxt_c;
      end
   end
`else
   assign bus.out_csum = 8'd0;
`endif

endmodule

// File: tb/tb_dsc_slice_depacketizer.sv
// Self-checking bench for dsc_slice_depacketizer: config table plus reset/stall/ignored-start sequences.
`timescale 1ns/1ps
module tb_dsc_slice_depacketizer;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_slice_width  = '0;
   logic [15:0] cfg_slice_height = '0;
   logic [9:0]  cfg_bpp          = '0;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   dsc_slice_depacketizer_if bus();

   dsc_slice_depacketizer #(.WIDTH_W(16), .BPP_W(10), .CHUNK_W(20)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .cfg_slice_width  (cfg_slice_width),
      .cfg_slice_height (cfg_slice_height),
      .cfg_bpp          (cfg_bpp),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .bus              (bus)
   );

   typedef struct {
      logic [7:0] data;
      logic       soc;
      logic       eoc;
      logic       eos;
      logic [7:0] csum;
   } beat_t;

   typedef struct {
      logic [15:0] width;
      logic [9:0]  bpp;
      logic [15:0] height;
      logic [7:0]  base;
      int          chunk;
      bit          exp_err;
      bit          gaps;
      bit          slow;
      bit          poke;
   } case_t;

   beat_t      exp_q[$];
   case_t      tbl[11];
   int         n_cmp  = 0;
   int         n_fail = 0;
   bit         err_case = 1'b0;
   logic [7:0] csum_run = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Output-side scoreboard, stall stability and done-pulse tracking.
   bit          stall_prev  = 1'b0;
   bit          expect_done = 1'b0;
   logic [19:0] snap;
   beat_t       e;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev  = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (stall_prev && bus.out_valid)
            check("stall_hold", 64'({bus.out_data, bus.out_soc, bus.out_eoc, bus.out_eos, bus.out_csum}),
                  64'(snap));
         if ((done && !err_case) || expect_done)
            check("done_pulse", 64'(done), 64'(expect_done));
         expect_done = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("beat", 64'({bus.out_data, bus.out_soc, bus.out_eoc, bus.out_eos}),
                     64'({e.data, e.soc, e.eoc, e.eos}));
               if (e.eoc) check("csum", 64'(bus.out_csum), 64'(e.csum));
               if (e.eos) expect_done = 1'b1;
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         snap       = {bus.out_data, bus.out_soc, bus.out_eoc, bus.out_eos, bus.out_csum};
      end
   end

   task automatic check_reset_vals(input string name);
      check(name, 64'({busy, done, err, bus.in_ready, bus.out_valid, bus.out_soc, bus.out_eoc,
                       bus.out_eos, bus.out_data, bus.out_csum}), 64'(0));
   endtask

   // One slice; abort_after >= 0 pulls rst_n after that many bytes have been accepted.
   task automatic run_case(input case_t c, input int abort_after);
      int n, idx, k, budget;
      bit got_done, rdy_seen;
      beat_t b;
      n        = c.exp_err ? 0 : c.chunk * int'(c.height);
      budget   = n * 4 + 40;
      idx      = 0;
      k        = 0;
      got_done = 1'b0;
      rdy_seen = 1'b0;
      err_case = c.exp_err;
      @(posedge clk); #1;
      start            = 1'b1;
      cfg_slice_width  = c.width;
      cfg_slice_height = c.height;
      cfg_bpp          = c.bpp;
      while (!got_done && k < budget) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c.poke && k == 5) begin
            start            = 1'b1;
            cfg_slice_height = 16'd0;
            cfg_slice_width  = 16'd7;
         end
         if (idx < n) begin
            bus.in_valid = c.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = c.base + 8'(idx);
         end else begin
            bus.in_valid = 1'b0;
         end
         bus.out_ready = c.slow ? (k % 3 == 0) : 1'b1;
         @(negedge clk);
         if (k == 0) begin
            check("busy_calc", 64'(busy), 64'(1));
            check("err_cleared", 64'(err), 64'(0));
         end
         if (bus.in_ready) rdy_seen = 1'b1;
         if (bus.in_valid && bus.in_ready) begin
            b.data = c.base + 8'(idx);
            b.soc  = (idx % c.chunk) == 0;
            b.eoc  = (idx % c.chunk) == c.chunk - 1;
            b.eos  = (idx == n - 1);
            csum_run = b.soc ? b.data : (csum_run ^ b.data);
`ifdef DSC_CHUNK_CSUM_EN
            b.csum = csum_run;
`else
            b.csum = 8'd0;
`endif
            exp_q.push_back(b);
            idx++;
            if (abort_after >= 0 && idx == abort_after) begin
               @(posedge clk); #1;
               rst_n        = 1'b0;
               bus.in_valid = 1'b0;
               #1 check_reset_vals("reset_mid_slice");
               exp_q.delete();
               @(posedge clk); #1;
               rst_n = 1'b1;
               return;
            end
         end
         if (done) begin
            got_done = 1'b1;
            if (c.exp_err) check("err_done_cycle", 64'(k), 64'(1));
         end
         k++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("done_seen", 64'(got_done), 64'(1));
      check("err_flag", 64'(err), 64'(c.exp_err));
      check("byte_count", 64'(idx), 64'(n));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
      if (c.exp_err) check("no_in_ready", 64'(rdy_seen), 64'(0));
      @(negedge clk);
      check("busy_after", 64'(busy), 64'(0));
      check("in_ready_idle", 64'(bus.in_ready), 64'(0));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           width    bpp      height  base   chunk err gaps slow poke
      tbl[0]  = '{16'd8,    10'd128, 16'd2, 8'h00, 8,    0,  0,   0,   0};
      tbl[1]  = '{16'd5,    10'd120, 16'd3, 8'h20, 5,    0,  0,   0,   0};
      tbl[2]  = '{16'd8,    10'd128, 16'd2, 8'h00, 8,    0,  1,   1,   0};
      tbl[3]  = '{16'd8,    10'd128, 16'd0, 8'h00, 8,    1,  0,   0,   0};
      tbl[4]  = '{16'd3,    10'd16,  16'd4, 8'h40, 1,    0,  0,   0,   0};
      tbl[5]  = '{16'd8,    10'd128, 16'd1, 8'h01, 8,    0,  0,   0,   0};
      tbl[6]  = '{16'd0,    10'd128, 16'd2, 8'h00, 0,    1,  0,   0,   0};
      tbl[7]  = '{16'd1,    10'd0,   16'd1, 8'h00, 0,    1,  0,   0,   0};
      tbl[8]  = '{16'd1000, 10'd200, 16'd1, 8'h80, 1563, 0,  1,   0,   1};
      tbl[9]  = '{16'd1,    10'd1,   16'd1, 8'hAA, 1,    0,  0,   0,   0};
      tbl[10] = '{16'd5,    10'd120, 16'd3, 8'h60, 5,    0,  0,   1,   1};

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset_values");
      rst_n = 1'b1;

      // Bytes offered while idle must not be taken.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      repeat (3) begin
         @(negedge clk);
         check("idle_in_ready", 64'({bus.in_ready, bus.out_valid}), 64'(0));
      end
      bus.in_valid = 1'b0;

      for (int i = 0; i < 11; i++) run_case(tbl[i], -1);

      // Reset mid-slice, then the same slice again from scratch.
      run_case(tbl[0], 5);
      @(negedge clk);
      check_reset_vals("post_reset_idle");
      run_case(tbl[0], -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
